// File: rtl/ping_arrival_timestamper.sv
// ping_arrival_timestamper: per-channel rising-threshold arrival timestamping relative to the first crossing channel.
//   clk            system clock
//   rst            asynchronous active-high reset
//   i_sample_valid one new sample per channel this cycle
//   i_sample_data  channel i at [i*DATA_W +: DATA_W]
//   i_threshold    unsigned crossing level, applied live
//   o_rec_valid    one-cycle pulse marking a fresh record
//   o_arrival      channel i arrival at [i*TS_W +: TS_W], samples since first crossing
//   o_hit_mask     channels that crossed inside the window
//   o_first_ch     lowest channel crossing at time 0
//   o_timeout      record closed by window expiry with channels missing
//   o_busy         high whenever not idle
module ping_arrival_timestamper #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 4,
    parameter int TS_W    = 8,
    parameter int WINDOW  = 20,
    parameter int HOLDOFF = 5,
    localparam int CW     = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_sample_valid,
    input  logic [N_CH*DATA_W-1:0] i_sample_data,
    input  logic [DATA_W-1:0]    i_threshold,
    output logic                 o_rec_valid,
    output logic [N_CH*TS_W-1:0] o_arrival,
    output logic [N_CH-1:0]      o_hit_mask,
    output logic [CW-1:0]        o_first_ch,
    output logic                 o_timeout,
    output logic                 o_busy
);
    localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_REPORT, S_HOLDOFF} state_t;
    state_t r_state;
    logic [N_CH-1:0] w_above, w_cross, w_new, w_hit_n, r_above_prev, r_hit;
    logic [N_CH*TS_W-1:0] w_arr_n, r_arr;
    logic [TS_W-1:0] w_cnt_n, r_win_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic [CW-1:0] w_first, r_first;
    logic w_idle, w_done;
    assign o_busy = r_state != S_IDLE;
    always_comb begin
        w_idle  = r_state == S_IDLE;
        w_cnt_n = r_win_cnt + 1'b1;
        w_first = '0;
        w_above = '0;
        w_cross = '0;
        // descending scan leaves the lowest crossing index in w_first
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_above[i] = i_sample_data[i*DATA_W +: DATA_W] >= i_threshold;
            w_cross[i] = i_sample_valid && w_above[i] && !r_above_prev[i];
            if (w_cross[i]) w_first = CW'(i);
        end
        w_new   = w_idle ? w_cross : (r_state == S_CAPTURE ? w_cross & ~r_hit : '0);
        w_hit_n = (w_idle ? '0 : r_hit) | w_new;
        w_arr_n = '0;
        for (int i = 0; i < N_CH; i++)
            w_arr_n[i*TS_W +: TS_W] = w_idle ? '0 : (w_new[i] ? w_cnt_n : r_arr[i*TS_W +: TS_W]);
        w_done  = w_idle ? (|w_cross && &w_hit_n)
                         : (r_state == S_CAPTURE && i_sample_valid && (&w_hit_n || w_cnt_n == TS_W'(WINDOW)));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_above_prev <= '1;
            r_hit        <= '0;
            r_arr        <= '0;
            r_win_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_first      <= '0;
            o_rec_valid  <= 1'b0;
            o_arrival    <= '0;
            o_hit_mask   <= '0;
            o_first_ch   <= '0;
            o_timeout    <= 1'b0;
        end else begin
            o_rec_valid <= 1'b0;
            if (i_sample_valid) r_above_prev <= w_above;
            if (w_done) begin
                o_rec_valid <= 1'b1;
                o_arrival   <= w_arr_n;
                o_hit_mask  <= w_hit_n;
                o_first_ch  <= w_idle ? w_first : r_first;
                o_timeout   <= ~&w_hit_n;
            end
            case (r_state)
                S_IDLE: if (|w_cross) begin
                    r_state   <= w_done ? S_REPORT : S_CAPTURE;
                    r_hit     <= w_hit_n;
                    r_arr     <= w_arr_n;
                    r_win_cnt <= '0;
                    r_first   <= w_first;
                end
                S_CAPTURE: if (i_sample_valid) begin
                    r_win_cnt <= w_cnt_n;
                    r_hit     <= w_hit_n;
                    r_arr     <= w_arr_n;
                    if (w_done) r_state <= S_REPORT;
                end
                S_REPORT: begin
                    r_hit      <= '0;
                    r_hold_cnt <= '0;
                    r_state    <= HOLDOFF == 0 ? S_IDLE : S_HOLDOFF;
                end
                default: if (i_sample_valid) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (r_hold_cnt == HW'(HOLDOFF - 1)) r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/ping_arrival_timestamper.md
Name: ping_arrival_timestamper

Overview:
- Per-hydrophone ping arrival detector. Sits between the hydrophone sample stream and the TDOA calculation stage.
- Detects a rising threshold crossing on each channel and timestamps every channel relative to the first channel that crosses.
- Emits one arrival-time record per ping, then ignores reverberation for a holdoff period.

Parameters:
- N_CH, 4, number of hydrophone channels.
- DATA_W, 4, unsigned sample width per channel.
- TS_W, 8, arrival timestamp width. Requires WINDOW < 2^TS_W.
- WINDOW, 20, samples after the first crossing during which the other channels may still arrive.
- HOLDOFF, 5, samples ignored after each report. 0 means return straight to IDLE.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one new sample per channel this cycle.
- sample_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- threshold  in  DATA_W  unsigned crossing level, used live.
- rec_valid  out  1  one-cycle pulse; the record outputs below are valid.
- arrival  out  N_CH*TS_W  arrival time of channel i at [i*TS_W +: TS_W], in samples since the first crossing.
- hit_mask  out  N_CH  bit i is set if channel i crossed within the window.
- first_ch  out  clog2(N_CH)  lowest-index channel that crossed at time 0.
- timeout  out  1  record closed by window expiry with at least one channel missing.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; above_prev[i] = 1.
  - above_prev reset to 1 ensures an input held high through reset does not trigger a capture.
- Crossing on channel i: sample_valid && (sample_data[i] >= threshold) && !above_prev[i].
- above_prev[i] updates to (sample_data[i] >= threshold) on every sample_valid, in every state.
- Cycles with sample_valid=0 change nothing: no time advance, no crossings, no edge-history update.
- FSM states: IDLE, CAPTURE, REPORT, HOLDOFF.
- IDLE:
  - On the first sample with any crossing: every crossing channel gets time 0 and its hit bit set.
  - first_ch = lowest crossing index; win_cnt = 0.
  - If all channels hit on that sample, go to REPORT; otherwise go to CAPTURE.
- CAPTURE:
  - Each sample_valid: win_cnt += 1.
  - Each new crossing on a channel without a hit records arrival = new win_cnt and sets its hit bit.
  - Further crossings on an already-hit channel are ignored.
  - Go to REPORT when all hit bits are set, or when win_cnt reaches WINDOW, whichever comes first. Hits on the sample where win_cnt reaches WINDOW still count.
- REPORT:
  - Lasts exactly one cycle with rec_valid = 1.
  - arrival, hit_mask, first_ch and timeout are registered and stable during that cycle.
  - timeout = !(&hit_mask).
  - Missing channels report arrival = 0 with their hit bit clear.
  - Record outputs hold their values until the next REPORT; only rec_valid pulses.
  - Next state: HOLDOFF, or IDLE if HOLDOFF = 0.
- HOLDOFF:
  - Counts HOLDOFF sample_valid cycles, ignoring all crossings, then goes to IDLE.
  - Hit bits clear on entry to IDLE.
- Latency: rec_valid rises on the cycle immediately after the clock edge that samples the completing crossing, or the WINDOW-th sample.
- Simultaneous crossings on one sample get identical timestamps.
- No backpressure: the consumer must accept the rec_valid pulse.
- Reset mid-capture clears all state immediately. No partial record is emitted. The next ping times from 0.
- threshold changes take effect on the next sample, including mid-capture.

Test Plan:
Common setup: defaults, threshold = 8, sample_valid = 1 every cycle, channel idle level 2, ping level 12.
1. Ch2 rises at sample 0, ch0 at 3, ch1 at 5, ch3 at 7 -> rec_valid one cycle after sample 7; arrival = {ch0 3, ch1 5, ch2 0, ch3 7}; hit_mask = 1111; first_ch = 2; timeout = 0.
2. Ch0 and ch1 rise at sample 0, ch2 at 4, ch3 never -> rec_valid after sample 20; arrival = {0, 0, 4, 0}; hit_mask = 0111; first_ch = 0; timeout = 1. Also ch3 rising exactly at sample 20 -> arrival3 = 20, hit_mask = 1111, timeout = 0.
3. After a report, ch0 falls and re-rises 2 samples later -> ignored, busy stays high. A rise 6 samples after REPORT starts a new capture with ch0 at time 0.
4. All channels held at 15 across reset release -> no capture. All drop to 2 for one sample and rise again -> capture; all four at 0; rec_valid on the next cycle.
5. Assert rst after 2 channels hit -> all outputs 0 asynchronously, state IDLE. A new ping after release times from 0 and never produces rec_valid from the aborted capture.
6. Scenario 1 with sample_valid low on every other cycle -> identical arrival values; rec_valid one cycle after the completing valid sample.
